// File: rtl/tempsens_pkg.sv
// Shared types and default constants for the ring-oscillator temperature
// sensor sequencer and its settle/timeout timer.
package tempsens_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_ACCUM   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  localparam int DEF_N              = 8;
  localparam int DEF_SETTLE_CYCLES  = 16;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // Timer width large enough to hold the longer of the two load values.
  function automatic int timer_width(input int settle, input int timeout);
    int longest;
    longest = (settle > timeout) ? settle : timeout;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/tempsens_timer.sv
// Loadable down-counter that stops at zero instead of wrapping. The zero
// flag is decoded from the count register, so it has no path from inputs.
module tempsens_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  // Reload on request, otherwise count down and hold once zero is reached.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/tempsens_sequencer.sv
// Measurement sequencer for the ring-oscillator temperature sensor: runs the
// oscillator through a settle period, enables the averager until its sum is
// ready, captures the result and offers it on a valid/ready handshake.
// Optional macro TEMPSENS_TIMEOUT_EN: abort ACCUM after TIMEOUT_CYCLES
// cycles without avg_ready and raise the sticky err_timeout flag.
module tempsens_sequencer
  import tempsens_pkg::*;
#(
  parameter int N              = DEF_N,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         cont_mode,
  input  logic         stop,
  output logic         ro_en,
  output logic         avg_en,
  output logic         avg_sum_en,
  input  logic         avg_ready,
  input  logic [N-1:0] avg_result,
  output logic [N-1:0] result_data,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         busy,
  output logic         err_timeout
);

  localparam int TW = timer_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
`ifdef TEMPSENS_TIMEOUT_EN
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
`else
  localparam logic [TW-1:0] TIMEOUT_LOAD = '0;
`endif

  state_e       state_q, state_d;
  logic [N-1:0] result_data_q, result_data_d;
  logic         err_timeout_q, err_timeout_d;
  logic         ro_en_q, avg_en_q, avg_sum_en_q, result_valid_q, busy_q;
  logic         timer_load;
  logic [TW-1:0] timer_load_val;
  logic         timer_zero;

  tempsens_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_load_val),
    .zero     (timer_zero)
  );

  // Next-state, capture and error-flag logic; stop overrides every transition.
  always_comb begin
    state_d       = state_q;
    result_data_d = result_data_q;
    err_timeout_d = err_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_WARMUP;
          err_timeout_d = 1'b0;
        end
      end
      ST_WARMUP: begin
        if (timer_zero) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (avg_ready) begin
          state_d = ST_CAPTURE;
`ifdef TEMPSENS_TIMEOUT_EN
        end else if (timer_zero) begin
          state_d       = ST_IDLE;
          err_timeout_d = 1'b1;
`endif
        end
      end
      ST_CAPTURE: begin
        result_data_d = avg_result;
        state_d       = ST_HOLD;
      end
      ST_HOLD: begin
        if (result_ready) state_d = cont_mode ? ST_WARMUP : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (stop) begin
      state_d       = ST_IDLE;
      result_data_d = result_data_q;
      err_timeout_d = err_timeout_q;
    end
`ifndef TEMPSENS_TIMEOUT_EN
    err_timeout_d = 1'b0;
`endif
  end

  // Reload the timer on every state entry with that state's period.
  always_comb begin
    timer_load     = (state_d != state_q);
    timer_load_val = (state_d == ST_ACCUM) ? TIMEOUT_LOAD : SETTLE_LOAD;
  end

  // FSM state, captured data and registered outputs derived from next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      result_data_q  <= '0;
      err_timeout_q  <= 1'b0;
      ro_en_q        <= 1'b0;
      avg_en_q       <= 1'b0;
      avg_sum_en_q   <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      result_data_q  <= result_data_d;
      err_timeout_q  <= err_timeout_d;
      ro_en_q        <= (state_d == ST_WARMUP) || (state_d == ST_ACCUM);
      avg_en_q       <= (state_d == ST_ACCUM) || (state_d == ST_CAPTURE);
      avg_sum_en_q   <= (state_d == ST_ACCUM);
      result_valid_q <= (state_d == ST_HOLD);
      busy_q         <= (state_d != ST_IDLE);
    end
  end

  assign ro_en        = ro_en_q;
  assign avg_en       = avg_en_q;
  assign avg_sum_en   = avg_sum_en_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign result_data  = result_data_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_tempsens_sequencer.sv
// Self-checking bench for tempsens_sequencer. Expected averager results are
// queued when avg_ready is driven and compared at each accepted handshake.
// Timeout behaviour is exercised according to TEMPSENS_TIMEOUT_EN.
module tb_tempsens_sequencer;

  localparam int N       = 8;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 255;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, cont_mode, stop;
  logic         ro_en, avg_en, avg_sum_en;
  logic         avg_ready;
  logic [N-1:0] avg_result;
  logic [N-1:0] result_data;
  logic         result_valid, result_ready;
  logic         busy, err_timeout;

  int           assertCount = 0;
  int           failCount   = 0;
  logic [N-1:0] expQ[$];
  logic [N-1:0] lastData;

  tempsens_sequencer #(
    .N              (N),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cont_mode    (cont_mode),
    .stop         (stop),
    .ro_en        (ro_en),
    .avg_en       (avg_en),
    .avg_sum_en   (avg_sum_en),
    .avg_ready    (avg_ready),
    .avg_result   (avg_result),
    .result_data  (result_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  // Count one comparison and report it when the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: at every accepted handshake the data must match the queue head.
  always @(negedge clk) begin
    if (reset && result_valid && result_ready) begin
      checkOutput("sb_pending", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) checkOutput("sb_data", 32'(result_data), 32'(expQ.pop_front()));
    end
  end

  // Count WARMUP cycles starting in the first WARMUP cycle; ends in ACCUM.
  task automatic measureWarmup(input string tag);
    int n;
    n = 0;
    while (ro_en && !avg_sum_en && n < 200) begin
      n++;
      tick();
    end
    checkOutput({tag, "_warmup_len"}, 32'(n), 32'(SETTLE));
    checkOutput({tag, "_accum_en"}, 32'({ro_en, avg_en, avg_sum_en}), 32'h7);
  endtask

  // From the first ACCUM cycle, raise avg_ready in ACCUM cycle 'cycles' and
  // follow the result through CAPTURE into the first HOLD cycle.
  task automatic applyStimulus(input logic [N-1:0] val, input int cycles);
    repeat (cycles - 1) tick();
    checkOutput("accum_still", 32'(avg_sum_en), 32'd1);
    avg_ready  = 1'b1;
    avg_result = val;
    expQ.push_back(val);
    tick();
    avg_ready = 1'b0;
    checkOutput("capture_outs", 32'({ro_en, avg_en, avg_sum_en, result_valid}), 32'h4);
    tick();
    avg_result = ~val;
    checkOutput("hold_valid", 32'({busy, result_valid}), 32'h3);
    checkOutput("hold_data", 32'(result_data), 32'(val));
    lastData = val;
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    cont_mode    = 1'b0;
    stop         = 1'b0;
    avg_ready    = 1'b0;
    avg_result   = '0;
    result_ready = 1'b0;
    lastData     = '0;

    tick();
    checkOutput("reset_outs", 32'({ro_en, avg_en, avg_sum_en, result_valid, busy,
                                   err_timeout, result_data}), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("idle_outs", 32'({ro_en, avg_en, avg_sum_en, result_valid, busy}), 32'h0);

    // Single shot with backpressure.
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start_busy", 32'({busy, ro_en, avg_sum_en}), 32'h6);
    measureWarmup("t1");
    applyStimulus(8'h5A, 101);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("bp_valid", 32'(result_valid), 32'd1);
      checkOutput("bp_data", 32'(result_data), 32'h5A);
    end
    start        = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    checkOutput("accept_idle", 32'({busy, result_valid, ro_en}), 32'h0);
    checkOutput("accept_data_kept", 32'(result_data), 32'h5A);
    tick();
    checkOutput("still_idle", 32'(busy), 32'd0);

    // Continuous mode: two back-to-back measurements, 1-cycle HOLD each.
    cont_mode    = 1'b1;
    result_ready = 1'b1;
    start        = 1'b1;
    tick();
    start = 1'b0;
    measureWarmup("t2a");
    applyStimulus(8'h10, 101);
    tick();
    checkOutput("rearm", 32'({busy, ro_en, result_valid}), 32'h6);
    cont_mode = 1'b0;
    measureWarmup("t2b");
    applyStimulus(8'h20, 101);
    tick();
    checkOutput("cont_done", 32'({busy, result_valid}), 32'h0);
    result_ready = 1'b0;

`ifdef TEMPSENS_TIMEOUT_EN
    // Timeout: avg_ready never arrives.
    start = 1'b1;
    tick();
    start = 1'b0;
    measureWarmup("t3");
    begin
      int n;
      n = 0;
      while (avg_sum_en && n < 400) begin
        n++;
        tick();
      end
      checkOutput("timeout_len", 32'(n), 32'(TIMEOUT));
    end
    checkOutput("timeout_err", 32'({err_timeout, busy}), 32'h2);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("err_cleared", 32'({err_timeout, busy}), 32'h1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("stop_warmup", 32'(busy), 32'd0);
`else
    // Without timeout, ACCUM waits indefinitely and no error is raised.
    start = 1'b1;
    tick();
    start = 1'b0;
    measureWarmup("t3");
    repeat (300) tick();
    checkOutput("no_timeout", 32'({avg_sum_en, err_timeout}), 32'h2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("stop_accum", 32'({busy, ro_en, avg_en}), 32'h0);
`endif

    // Abort: stop together with avg_ready in ACCUM.
    start = 1'b1;
    tick();
    start = 1'b0;
    measureWarmup("t4");
    repeat (10) tick();
    avg_ready  = 1'b1;
    avg_result = 8'h77;
    stop       = 1'b1;
    tick();
    avg_ready = 1'b0;
    stop      = 1'b0;
    checkOutput("abort_outs", 32'({ro_en, avg_en, avg_sum_en, result_valid, busy}), 32'h0);
    repeat (2) tick();
    checkOutput("abort_no_valid", 32'(result_valid), 32'd0);
    checkOutput("abort_data_kept", 32'(result_data), 32'(lastData));

    // Reset while a result is pending in HOLD.
    start = 1'b1;
    tick();
    start = 1'b0;
    measureWarmup("t5");
    applyStimulus(8'h33, 5);
    void'(expQ.pop_back());
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("reset_hold", 32'({ro_en, avg_en, avg_sum_en, result_valid, busy,
                                   err_timeout, result_data}), 32'h0);
    tick();
    checkOutput("post_reset_idle", 32'(busy), 32'd0);

    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
